// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared definitions for the hardwired control sequencer.
//                Contents: opcodes, ALU function codes (shared with the ALU),
//                sequencer states, instruction classes, IR field positions
//                and the opcode decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Positions of the instruction fields within IR
    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function codes; the ALU decodes exactly these values
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_ROR  = 4'd6;
    localparam logic [3:0] ALU_SHL  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_REGREG  = 3'd0,
        CLS_UNARY   = 3'd1,
        CLS_MULDIV  = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  return CLS_REGREG;
            OP_NEG, OP_NOT:                   return CLS_UNARY;
            OP_MUL, OP_DIV:                   return CLS_MULDIV;
            OP_NOP:                           return CLS_NOP;
            OP_HALT:                          return CLS_HALT;
            default:                          return CLS_ILLEGAL;
        endcase
    endfunction

    // Opcode numbering differs from ALU numbering (SHL/ROR are swapped)
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHRA: return ALU_SHRA;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Control bus between the sequencer and the datapath.
//                IR flows datapath -> sequencer; all strobes, ALUop and
//                status flags flow sequencer -> datapath.
//                master : sequencer side      slave : datapath side
//  Revision    : 1.0  initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int NREG = 16
);
    logic [31:0]     IR;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Read;
    logic            Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
    logic [3:0]      ALUop;
    logic            busy, halted, illegal;

    modport master (
        input  IR,
        output Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Read,
        output Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        output ALUop, busy, halted, illegal
    );

    modport slave (
        output IR,
        input  Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Read,
        input  Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        input  ALUop, busy, halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/reg_select.sv
`default_nettype none
// ============================================================================
//  Module      : reg_select
//  Description : 4-bit register field plus enable -> one-hot register select.
//                Ports: field (register number), en (select enable),
//                       onehot (NREG-bit select, all-zero when disabled).
//  Revision    : 1.0  initial release
// ============================================================================
module reg_select #(
    parameter int NREG = 16
) (
    input  wire logic [3:0]      field,
    input  wire logic            en,
    output      logic [NREG-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (field == 4'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired control unit. Fetches (T0-T2) from PC, then
//                executes the 3-register instruction in IR (T3-T6).
//                Ports: clock (rising edge), clear (async, active low),
//                       run (keep executing / finish and idle),
//                       bus   (IR in; datapath strobes, ALUop, busy, halted,
//                              illegal out).
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG = 16
) (
    input  wire logic            clock,
    input  wire logic            clear,
    input  wire logic            run,
    control_sequencer_if.master  bus
);
    state_t          r_state;
    op_class_t       w_cls;
    logic [3:0]      w_alu;
    logic            w_ra_en, w_rb_en, w_rc_en;
    logic [NREG-1:0] w_rin, w_rout_b, w_rout_c;
    state_t          w_end_state;
    logic            w_unused_ir;

    assign w_cls       = op_class(bus.IR[IR_OP_MSB:IR_OP_LSB]);
    assign w_alu       = alu_code(bus.IR[IR_OP_MSB:IR_OP_LSB]);
    assign w_end_state = run ? ST_T0 : ST_IDLE;
    assign w_unused_ir = ^bus.IR[IR_RC_LSB-1:0];

    // Rb and Rc selects are enabled in different states, so OR-ing them
    // never yields more than one bit.
    reg_select #(.NREG(NREG)) u_sel_ra (
        .field (bus.IR[IR_RA_MSB:IR_RA_LSB]), .en (w_ra_en), .onehot (w_rin));
    reg_select #(.NREG(NREG)) u_sel_rb (
        .field (bus.IR[IR_RB_MSB:IR_RB_LSB]), .en (w_rb_en), .onehot (w_rout_b));
    reg_select #(.NREG(NREG)) u_sel_rc (
        .field (bus.IR[IR_RC_MSB:IR_RC_LSB]), .en (w_rc_en), .onehot (w_rout_c));

    assign bus.Rin  = w_rin;
    assign bus.Rout = w_rout_b | w_rout_c;

    // State register; IR is only consulted from T3 onward
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= run ? ST_T0 : ST_IDLE;
                ST_T0:   r_state <= ST_T1;
                ST_T1:   r_state <= ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3: begin
                    case (w_cls)
                        CLS_HALT:             r_state <= ST_HALT;
                        CLS_NOP, CLS_ILLEGAL: r_state <= w_end_state;
                        default:              r_state <= ST_T4;
                    endcase
                end
                ST_T4:   r_state <= (w_cls == CLS_UNARY)  ? w_end_state : ST_T5;
                ST_T5:   r_state <= (w_cls == CLS_MULDIV) ? ST_T6 : w_end_state;
                ST_T6:   r_state <= w_end_state;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Moore output decode; reset forces IDLE, so every output clears at once
    always_comb begin
        w_ra_en      = 1'b0;
        w_rb_en      = 1'b0;
        w_rc_en      = 1'b0;
        bus.PCin     = 1'b0;
        bus.PCout    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Read     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.Zhighin  = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.ALUop    = 4'd0;
        bus.illegal  = 1'b0;
        bus.halted   = (r_state == ST_HALT);
        bus.busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
        case (r_state)
            ST_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_REGREG, CLS_MULDIV: begin
                        w_rb_en = 1'b1; bus.Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        // Single-operand ops go straight to the ALU in T3
                        w_rb_en = 1'b1; bus.ALUop = w_alu; bus.Zlowin = 1'b1;
                    end
                    CLS_ILLEGAL: bus.illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_REGREG: begin
                        w_rc_en = 1'b1; bus.ALUop = w_alu; bus.Zlowin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_rc_en = 1'b1; bus.ALUop = w_alu;
                        bus.Zlowin = 1'b1; bus.Zhighin = 1'b1;
                    end
                    CLS_UNARY: begin
                        bus.Zlowout = 1'b1; w_ra_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_REGREG: begin
                        bus.Zlowout = 1'b1; w_ra_en = 1'b1;
                    end
                    CLS_MULDIV: begin
                        bus.Zlowout = 1'b1; bus.LOin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (w_cls == CLS_MULDIV) begin
                    bus.Zhighout = 1'b1; bus.HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Directed self-checking bench for control_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    // Strobe bit positions inside the 15-bit strobe group
    localparam logic [14:0] S_PCIN     = 15'h4000;
    localparam logic [14:0] S_PCOUT    = 15'h2000;
    localparam logic [14:0] S_INCPC    = 15'h1000;
    localparam logic [14:0] S_MARIN    = 15'h0800;
    localparam logic [14:0] S_MDRIN    = 15'h0400;
    localparam logic [14:0] S_MDROUT   = 15'h0200;
    localparam logic [14:0] S_IRIN     = 15'h0100;
    localparam logic [14:0] S_READ     = 15'h0080;
    localparam logic [14:0] S_YIN      = 15'h0040;
    localparam logic [14:0] S_ZLOWIN   = 15'h0020;
    localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] S_ZLOWOUT  = 15'h0008;
    localparam logic [14:0] S_ZHIGHOUT = 15'h0004;
    localparam logic [14:0] S_LOIN     = 15'h0002;
    localparam logic [14:0] S_HIIN     = 15'h0001;

    logic clock;
    logic clear;
    logic run;
    int   n_checks;
    int   n_fail;

    control_sequencer_if #(.NREG(16)) bus ();

    control_sequencer #(.NREG(16)) dut (
        .clock (clock),
        .clear (clear),
        .run   (run),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [53:0] observed();
        return {bus.Rin, bus.Rout,
                bus.PCin, bus.PCout, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Read, bus.Yin, bus.Zlowin, bus.Zhighin, bus.Zlowout,
                bus.Zhighout, bus.LOin, bus.HIin,
                bus.ALUop, bus.busy, bus.halted, bus.illegal};
    endfunction

    function automatic logic [53:0] ev(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [14:0] s, input logic [3:0] alu,
                                       input logic b, input logic h, input logic il);
        return {rin, rout, s, alu, b, h, il};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    // Advance one clock; sampling/driving happens 1 time unit after the edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Starting in T0: check the three fetch cycles, leave the DUT in T3
    task automatic test_fetch(input string tag);
        logic [53:0] exp_t [3];
        exp_t[0] = ev(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_t[1] = ev(16'h0, 16'h0, S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_t[2] = ev(16'h0, 16'h0, S_MDROUT | S_IRIN, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            n_checks++;
            if (observed() !== exp_t[t]) begin
                n_fail++;
                $display("FAIL %s_fetch_T%0d: got %h expected %h", tag, t, observed(), exp_t[t]);
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        clear  = 1'b0;
        run    = 1'b0;
        bus.IR = 32'h0;
        cyc();
        cyc();
        n_checks++;
        if (observed() !== ev(16'h0, 16'h0, 15'h0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (observed() !== ev(16'h0, 16'h0, 15'h0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL idle_hold_%0d: got %h expected 0", i, observed());
            end
        end
    endtask

    // SHL R7,R0,R4 from IDLE; leaves DUT in the next T0 with run=1
    task automatic test_shl();
        logic [53:0] e;
        bus.IR = 32'h33820000;
        run    = 1'b1;
        cyc();
        test_fetch("shl");
        e = ev(16'h0, 16'h0001, S_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL shl_T3: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0, 16'h0010, S_ZLOWIN, 4'd7, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL shl_T4: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0080, 16'h0, S_ZLOWOUT, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL shl_T5: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL shl_next_T0: got %h expected %h", observed(), e); end
    endtask

    // MUL with Ra=1, Rb=Rc=0, starting from T0; ends in the next T0
    task automatic test_mul();
        logic [53:0] e [4];
        bus.IR = 32'h48800000;
        e[0] = ev(16'h0, 16'h0001, S_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
        e[1] = ev(16'h0, 16'h0001, S_ZLOWIN | S_ZHIGHIN, 4'd9, 1'b1, 1'b0, 1'b0);
        e[2] = ev(16'h0, 16'h0, S_ZLOWOUT | S_LOIN, 4'd0, 1'b1, 1'b0, 1'b0);
        e[3] = ev(16'h0, 16'h0, S_ZHIGHOUT | S_HIIN, 4'd0, 1'b1, 1'b0, 1'b0);
        test_fetch("mul");
        for (int t = 0; t < 4; t++) begin
            n_checks++;
            if (observed() !== e[t]) begin
                n_fail++;
                $display("FAIL mul_T%0d: got %h expected %h", t + 3, observed(), e[t]);
            end
            cyc();
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.MARin !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_next_T0: busy=%b MARin=%b expected 1 1", bus.busy, bus.MARin);
        end
    endtask

    // NEG R4,R9 from T0: two execute cycles, then back to T0
    task automatic test_unary();
        logic [53:0] e;
        bus.IR = mk_ir(5'b01011, 4'd4, 4'd9, 4'd0);
        test_fetch("neg");
        e = ev(16'h0, 16'h0200, S_ZLOWIN, 4'd11, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL neg_T3: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0010, 16'h0, S_ZLOWOUT, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL neg_T4: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL neg_next_T0: got %h expected %h", observed(), e); end
    endtask

    // HALT from T0; clear pulse returns to IDLE (run dropped afterwards)
    task automatic test_halt();
        logic [53:0] e;
        bus.IR = 32'hD8000000;
        test_fetch("halt");
        e = ev(16'h0, 16'h0, 15'h0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL halt_T3: got %h expected %h", observed(), e); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            e = ev(16'h0, 16'h0, 15'h0, 4'd0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: got %h expected %h", i, observed(), e);
            end
        end
        run   = 1'b0;
        clear = 1'b0;
        #2;
        n_checks++;
        if (observed() !== 54'h0) begin n_fail++; $display("FAIL halt_clear: got %h expected 0", observed()); end
        cyc();
        clear = 1'b1;
        cyc();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_to_idle: busy=%b halted=%b expected 0 0", bus.busy, bus.halted);
        end
    endtask

    // Undefined opcode from IDLE, repeated once with run dropped
    task automatic test_illegal();
        logic [53:0] e;
        bus.IR = 32'hF8000000;
        run    = 1'b1;
        cyc();
        test_fetch("ill");
        e = ev(16'h0, 16'h0, 15'h0, 4'd0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL ill_T3: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL ill_next_T0: got %h expected %h", observed(), e); end
        run = 1'b0;
        cyc(); cyc(); cyc();
        n_checks++;
        if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL ill_second_T3: got %b expected 1", bus.illegal); end
        cyc();
        n_checks++;
        if (observed() !== 54'h0) begin n_fail++; $display("FAIL ill_to_idle: got %h expected 0", observed()); end
    endtask

    // ADD R2,R3,R5 with run dropped in T4: T5 still completes, then IDLE
    task automatic test_drop_run();
        logic [53:0] e;
        bus.IR = mk_ir(5'b00000, 4'd2, 4'd3, 4'd5);
        run    = 1'b1;
        cyc();
        test_fetch("add");
        e = ev(16'h0, 16'h0008, S_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL add_T3: got %h expected %h", observed(), e); end
        cyc();
        e = ev(16'h0, 16'h0020, S_ZLOWIN, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL add_T4: got %h expected %h", observed(), e); end
        run = 1'b0;
        cyc();
        e = ev(16'h0004, 16'h0, S_ZLOWOUT, 4'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed() !== e) begin n_fail++; $display("FAIL add_T5_run_low: got %h expected %h", observed(), e); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++;
            if (observed() !== 54'h0) begin
                n_fail++;
                $display("FAIL add_idle_%0d: got %h expected 0", i, observed());
            end
        end
    endtask

    // Asynchronous clear in T4 of an ADD: outputs drop before the next edge
    task automatic test_async_clear();
        bus.IR = mk_ir(5'b00000, 4'd2, 4'd3, 4'd5);
        run    = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        n_checks++;
        if (bus.Zlowin !== 1'b1 || bus.Rout !== 16'h0020) begin
            n_fail++;
            $display("FAIL aclr_in_T4: Zlowin=%b Rout=%h expected 1 0020", bus.Zlowin, bus.Rout);
        end
        #2;
        clear = 1'b0;
        #1;
        n_checks++;
        if (observed() !== 54'h0) begin n_fail++; $display("FAIL aclr_immediate: got %h expected 0", observed()); end
        run = 1'b0;
        cyc();
        clear = 1'b1;
        cyc();
        n_checks++;
        if (observed() !== 54'h0) begin n_fail++; $display("FAIL aclr_idle: got %h expected 0", observed()); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_shl();
        test_mul();
        test_unary();
        test_halt();
        test_illegal();
        test_drop_run();
        test_async_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
